// File: rtl/npc_ras_unit.sv
// rtl/npc_ras_unit.sv - fetch PC register, next-PC mux, return-address stack and redirect counter
module npc_ras_unit #(
    parameter logic [31:0] RESET_PC  = 32'h0000_3000,
    parameter logic [31:0] EXC_VEC   = 32'h0000_4180,
    parameter int          RAS_DEPTH = 4,
    parameter int          CNT_W     = 16
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         stall,
    input  logic [2:0]                   npc_op,
    input  logic                         cmp_suc,
    input  logic                         is_ra,
    input  logic [31:0]                  D_PC,
    input  logic [15:0]                  imm16,
    input  logic [25:0]                  imm26,
    input  logic [31:0]                  rs_val,
    input  logic                         exc_req,
    input  logic                         eret_req,
    input  logic [31:0]                  epc,
    output logic [31:0]                  F_PC,
    output logic [31:0]                  NPC,
    output logic                         ras_miss,
    output logic [$clog2(RAS_DEPTH):0]   ras_count,
    output logic [CNT_W-1:0]             redirect_cnt
);
    localparam int PW = $clog2(RAS_DEPTH);
    localparam logic [2:0] OP_BR   = 3'b001;
    localparam logic [2:0] OP_J    = 3'b010;
    localparam logic [2:0] OP_JAL  = 3'b011;
    localparam logic [2:0] OP_JR   = 3'b100;
    localparam logic [2:0] OP_JALR = 3'b101;
    localparam logic [PW:0]   FULL    = (PW+1)'(RAS_DEPTH);
    localparam logic [PW-1:0] PTR_ONE = PW'(1);
    localparam logic [PW:0]   CNT_ONE = (PW+1)'(1);

    logic [31:0]      f_pc_q;
    logic [31:0]      ras_q [RAS_DEPTH];
    logic [PW-1:0]    ptr_q, ptr_d;
    logic [PW:0]      count_q, count_d;
    logic             miss_q, miss_d;
    logic [CNT_W-1:0] redir_q, redir_d;

    logic             applied, taken, do_push, do_pop;
    logic [31:0]      target, br_pc, push_val;
    logic [PW-1:0]    top_idx;

    always_comb begin
        applied  = !stall && !exc_req && !eret_req;
        br_pc    = D_PC + 32'd4 + {{14{imm16[15]}}, imm16, 2'b00};
        push_val = D_PC + 32'd8;
        top_idx  = ptr_q - PTR_ONE;
        target   = f_pc_q + 32'd4;
        taken    = 1'b0;
        case (npc_op)
            OP_BR: begin
                if (cmp_suc) begin
                    target = br_pc;
                    taken  = 1'b1;
                end
            end
            OP_J, OP_JAL: begin
                target = {f_pc_q[31:28], imm26, 2'b00};
                taken  = 1'b1;
            end
            OP_JR, OP_JALR: begin
                target = rs_val;
                taken  = 1'b1;
            end
            default: ;
        endcase

        if (exc_req)       NPC = EXC_VEC;
        else if (eret_req) NPC = epc;
        else if (stall)    NPC = f_pc_q;
        else               NPC = target;

        do_push = applied && (npc_op == OP_JAL || npc_op == OP_JALR);
        do_pop  = applied && (npc_op == OP_JR) && is_ra;

        // Pushing when full overwrites the oldest slot simply by letting the pointer wrap.
        ptr_d   = ptr_q;
        count_d = count_q;
        miss_d  = 1'b0;
        if (do_push) begin
            ptr_d = ptr_q + PTR_ONE;
            if (count_q != FULL) count_d = count_q + CNT_ONE;
        end else if (do_pop) begin
            if (count_q == '0) begin
                miss_d = 1'b1;
            end else begin
                ptr_d   = top_idx;
                count_d = count_q - CNT_ONE;
                miss_d  = (ras_q[top_idx] != rs_val);
            end
        end

        redir_d = redir_q;
        if (applied && taken && redir_q != '1) redir_d = redir_q + 1'b1;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            f_pc_q  <= RESET_PC;
            ptr_q   <= '0;
            count_q <= '0;
            miss_q  <= 1'b0;
            redir_q <= '0;
            for (int i = 0; i < RAS_DEPTH; i++) ras_q[i] <= '0;
        end else begin
            f_pc_q  <= NPC;
            ptr_q   <= ptr_d;
            count_q <= count_d;
            miss_q  <= miss_d;
            redir_q <= redir_d;
            if (do_push) ras_q[ptr_q] <= push_val;
        end
    end

    assign F_PC         = f_pc_q;
    assign ras_miss     = miss_q;
    assign ras_count    = count_q;
    assign redirect_cnt = redir_q;
endmodule

// File: tb/tb_npc_ras_unit.sv
// tb/tb_npc_ras_unit.sv - vector table, corner sequences and randomized run against a queue-based model
module tb_npc_ras_unit;
    localparam int DEPTH = 4;
    localparam int CW    = 5;
    localparam int SAT   = (1 << CW) - 1;

    logic        clk = 0, reset = 1, stall = 0, cmp_suc = 0, is_ra = 0, exc_req = 0, eret_req = 0;
    logic [2:0]  npc_op = 0;
    logic [31:0] D_PC = 0, rs_val = 0, epc = 0;
    logic [15:0] imm16 = 0;
    logic [25:0] imm26 = 0;
    logic [31:0] F_PC, NPC;
    logic        ras_miss;
    logic [2:0]  ras_count;
    logic [CW-1:0] redirect_cnt;

    npc_ras_unit #(.RESET_PC(32'h3000), .EXC_VEC(32'h4180), .RAS_DEPTH(DEPTH), .CNT_W(CW)) dut (
        .clk(clk), .reset(reset), .stall(stall), .npc_op(npc_op), .cmp_suc(cmp_suc), .is_ra(is_ra),
        .D_PC(D_PC), .imm16(imm16), .imm26(imm26), .rs_val(rs_val), .exc_req(exc_req),
        .eret_req(eret_req), .epc(epc), .F_PC(F_PC), .NPC(NPC), .ras_miss(ras_miss),
        .ras_count(ras_count), .redirect_cnt(redirect_cnt));

    always #5 clk = ~clk;

    int n_total = 0, n_bad = 0;

    // Reference model: fetch PC, call stack as a bounded queue, plain counter.
    logic [31:0] m_fpc;
    logic [31:0] m_ras[$];
    bit          m_miss;
    int          m_rc;
    logic [31:0] npc_pre;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic m_reset();
        m_fpc = 32'h3000;
        m_ras.delete();
        m_miss = 0;
        m_rc = 0;
    endtask

    function automatic logic [31:0] m_npc();
        logic [31:0] off;
        off = {{16{imm16[15]}}, imm16} * 32'd4;
        if (exc_req) return 32'h4180;
        if (eret_req) return epc;
        if (stall) return m_fpc;
        case (npc_op)
            3'd1: return cmp_suc ? D_PC + 32'd4 + off : m_fpc + 32'd4;
            3'd2, 3'd3: return {m_fpc[31:28], imm26, 2'b00};
            3'd4, 3'd5: return rs_val;
            default: return m_fpc + 32'd4;
        endcase
    endfunction

    task automatic m_step();
        logic [31:0] n;
        n = m_npc();
        m_miss = 0;
        if (!stall && !exc_req && !eret_req) begin
            if (npc_op == 3'd3 || npc_op == 3'd5) begin
                m_ras.push_back(D_PC + 32'd8);
                if (m_ras.size() > DEPTH) void'(m_ras.pop_front());
            end else if (npc_op == 3'd4 && is_ra) begin
                if (m_ras.size() == 0) m_miss = 1;
                else m_miss = (m_ras.pop_back() != rs_val);
            end
            if ((npc_op == 3'd1 && cmp_suc) || (npc_op >= 3'd2 && npc_op <= 3'd5))
                if (m_rc < SAT) m_rc++;
        end
        m_fpc = n;
    endtask

    task automatic cyc(input logic [2:0] op, input bit cmp, input bit ra, input logic [31:0] dpc,
                       input logic [15:0] i16, input logic [25:0] i26, input logic [31:0] rs,
                       input bit st, input bit ex, input bit er, input logic [31:0] ep, input bit mchk);
        npc_op = op; cmp_suc = cmp; is_ra = ra; D_PC = dpc; imm16 = i16; imm26 = i26;
        rs_val = rs; stall = st; exc_req = ex; eret_req = er; epc = ep;
        #1;
        npc_pre = NPC;
        if (mchk) chk("npc", NPC, m_npc());
        @(posedge clk);
        m_step();
        #1;
        if (mchk) begin
            chk("f_pc", F_PC, m_fpc);
            chk("ras_count", 32'(ras_count), 32'(m_ras.size()));
            chk("ras_miss", 32'(ras_miss), 32'(m_miss));
            chk("redirect_cnt", 32'(redirect_cnt), 32'(m_rc));
        end
    endtask

    typedef struct {
        logic [2:0]  op;
        bit          cmp;
        bit          ra;
        logic [31:0] dpc;
        logic [15:0] i16;
        logic [25:0] i26;
        logic [31:0] rs;
        logic [31:0] fpc;
        int          cnt;
        bit          miss;
        int          rc;
    } vec_t;
    vec_t tbl[$];

    initial begin
        logic [31:0] f0;
        int c0, r0;

        tbl.push_back('{3'd0, 0, 0, 32'h0, 16'h0, 26'h0, 32'h0, 32'h3004, 0, 0, 0});
        tbl.push_back('{3'd0, 0, 0, 32'h0, 16'h0, 26'h0, 32'h0, 32'h3008, 0, 0, 0});
        tbl.push_back('{3'd0, 0, 0, 32'h0, 16'h0, 26'h0, 32'h0, 32'h300C, 0, 0, 0});
        tbl.push_back('{3'd1, 1, 0, 32'h3010, 16'hFFFC, 26'h0, 32'h0, 32'h3004, 0, 0, 1});
        tbl.push_back('{3'd1, 0, 0, 32'h3010, 16'hFFFC, 26'h0, 32'h0, 32'h3008, 0, 0, 1});
        tbl.push_back('{3'd3, 0, 0, 32'h3000, 16'h0, 26'h0C04, 32'h0, 32'h3010, 1, 0, 2});
        tbl.push_back('{3'd4, 0, 1, 32'h3020, 16'h0, 26'h0, 32'h3008, 32'h3008, 0, 0, 3});
        tbl.push_back('{3'd3, 0, 0, 32'h3000, 16'h0, 26'h0C04, 32'h0, 32'h3010, 1, 0, 4});
        tbl.push_back('{3'd4, 0, 1, 32'h3020, 16'h0, 26'h0, 32'h3100, 32'h3100, 0, 1, 5});
        tbl.push_back('{3'd0, 0, 0, 32'h0, 16'h0, 26'h0, 32'h0, 32'h3104, 0, 0, 5});
        for (int k = 0; k < 5; k++)
            tbl.push_back('{3'd3, 0, 0, 32'h3000 + 32'(k) * 32'h10, 16'h0, 26'h0C40, 32'h0,
                            32'h3100, (k < 3) ? k + 1 : 4, 0, 6 + k});
        for (int k = 0; k < 4; k++)
            tbl.push_back('{3'd4, 0, 1, 32'h3100, 16'h0, 26'h0, 32'h3048 - 32'(k) * 32'h10,
                            32'h3048 - 32'(k) * 32'h10, 3 - k, 0, 11 + k});
        tbl.push_back('{3'd4, 0, 1, 32'h3100, 16'h0, 26'h0, 32'h3008, 32'h3008, 0, 1, 15});
        tbl.push_back('{3'd4, 0, 0, 32'h3100, 16'h0, 26'h0, 32'h5000, 32'h5000, 0, 0, 16});
        tbl.push_back('{3'd7, 0, 0, 32'h0, 16'h0, 26'h0, 32'h0, 32'h5004, 0, 0, 16});
        tbl.push_back('{3'd2, 0, 0, 32'h0, 16'h0, 26'h0000400, 32'h0, 32'h1000, 0, 0, 17});
        tbl.push_back('{3'd5, 0, 0, 32'h1000, 16'h0, 26'h0, 32'h2000, 32'h2000, 1, 0, 18});

        m_reset();
        repeat (2) @(posedge clk);
        #1;
        chk("reset_f_pc", F_PC, 32'h3000);
        chk("reset_ras_count", 32'(ras_count), 32'd0);
        chk("reset_ras_miss", 32'(ras_miss), 32'd0);
        chk("reset_redirect_cnt", 32'(redirect_cnt), 32'd0);
        chk("reset_npc", NPC, 32'h3004);
        reset = 0;

        foreach (tbl[i]) begin
            cyc(tbl[i].op, tbl[i].cmp, tbl[i].ra, tbl[i].dpc, tbl[i].i16, tbl[i].i26, tbl[i].rs,
                0, 0, 0, 32'h0, 0);
            chk($sformatf("vec%0d_npc", i), npc_pre, tbl[i].fpc);
            chk($sformatf("vec%0d_f_pc", i), F_PC, tbl[i].fpc);
            chk($sformatf("vec%0d_ras_count", i), 32'(ras_count), 32'(tbl[i].cnt));
            chk($sformatf("vec%0d_ras_miss", i), 32'(ras_miss), 32'(tbl[i].miss));
            chk($sformatf("vec%0d_redirect_cnt", i), 32'(redirect_cnt), 32'(tbl[i].rc));
        end

        // JAL held by a stall: frozen PC, then exactly one push and one count.
        f0 = m_fpc; c0 = m_ras.size(); r0 = m_rc;
        repeat (3) begin
            cyc(3'd3, 0, 0, 32'h3000, 16'h0, 26'h0C40, 32'h0, 1, 0, 0, 32'h0, 1);
            chk("stall_f_pc", F_PC, f0);
        end
        cyc(3'd3, 0, 0, 32'h3000, 16'h0, 26'h0C40, 32'h0, 0, 0, 0, 32'h0, 1);
        chk("stall_rel_f_pc", F_PC, 32'h3100);
        chk("stall_rel_count", 32'(ras_count), 32'(c0 + 1));
        chk("stall_rel_cnt", 32'(redirect_cnt), 32'(r0 + 1));
        cyc(3'd0, 0, 0, 32'h0, 16'h0, 26'h0, 32'h0, 0, 0, 0, 32'h0, 1);
        chk("stall_once_count", 32'(ras_count), 32'(c0 + 1));

        // Exception overrides stall and flushes the JAL; eret then returns.
        c0 = m_ras.size(); r0 = m_rc;
        cyc(3'd3, 0, 0, 32'h3000, 16'h0, 26'h0C40, 32'h0, 1, 1, 0, 32'h0, 1);
        chk("exc_f_pc", F_PC, 32'h4180);
        chk("exc_no_push", 32'(ras_count), 32'(c0));
        chk("exc_no_cnt", 32'(redirect_cnt), 32'(r0));
        cyc(3'd4, 0, 1, 32'h0, 16'h0, 26'h0, 32'h0, 0, 0, 1, 32'h3020, 1);
        chk("eret_f_pc", F_PC, 32'h3020);
        chk("eret_no_pop", 32'(ras_count), 32'(c0));
        chk("eret_no_miss", 32'(ras_miss), 32'd0);
        cyc(3'd3, 0, 0, 32'h0, 16'h0, 26'h0, 32'h0, 0, 1, 1, 32'h3020, 1);
        chk("exc_over_eret", F_PC, 32'h4180);

        // Asynchronous reset while a miss pulse is showing.
        cyc(3'd4, 0, 1, 32'h0, 16'h0, 26'h0, 32'hDEAD_0000, 0, 0, 0, 32'h0, 1);
        #2 reset = 1;
        #1;
        chk("async_f_pc", F_PC, 32'h3000);
        chk("async_ras_count", 32'(ras_count), 32'd0);
        chk("async_ras_miss", 32'(ras_miss), 32'd0);
        chk("async_redirect_cnt", 32'(redirect_cnt), 32'd0);
        @(posedge clk);
        #1 reset = 0;
        m_reset();
        cyc(3'd4, 0, 1, 32'h0, 16'h0, 26'h0, 32'h0, 0, 0, 0, 32'h0, 1);

        for (int i = 0; i < 400; i++) begin
            logic [2:0]  op;
            logic [31:0] rs;
            bit st, ex, er;
            op = 3'($urandom_range(0, 7));
            st = ($urandom_range(0, 9) < 2);
            ex = ($urandom_range(0, 19) == 0);
            er = ($urandom_range(0, 19) == 0);
            rs = $urandom & 32'hFFFF_FFFC;
            if (m_ras.size() > 0 && $urandom_range(0, 2) != 0) rs = m_ras[m_ras.size() - 1];
            cyc(op, 1'($urandom), ($urandom_range(0, 3) != 0), $urandom & 32'hFFFF_FFFC,
                16'($urandom), 26'($urandom), rs, st, ex, er, $urandom & 32'hFFFF_FFFC, 1);
        end

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time budget");
        $fatal(1);
    end
endmodule

// File: doc/npc_ras_unit.md
# npc_ras_unit

Parametrised next-PC generator with the fetch PC register built in, for the 5-stage MIPS pipeline. Holds F_PC, resolves sequential/branch/jump/register targets decided in D, and takes exception-entry and eret redirects from M. Adds a return-address stack (RAS) that shadows call/return flow and flags return mispredictions. Adds a saturating redirect counter for performance statistics.

## Interface
- RESET_PC, 32'h0000_3000, F_PC value after reset
- EXC_VEC, 32'h0000_4180, exception handler entry
- RAS_DEPTH, 4, RAS entries; power of two, ≥2
- CNT_W, 16, redirect counter width
- clk  in  1  clock; all state updates on rising edge
- reset  in  1  asynchronous, active-high; clears all state immediately
- stall  in  1  F/D stall from hazard unit
- npc_op  in  3  D-stage op: 000 SEQ, 001 BR, 010 J, 011 JAL, 100 JR, 101 JALR, others treated as SEQ
- cmp_suc  in  1  branch condition true (BR only)
- is_ra  in  1  D instruction's rs field == 31
- D_PC  in  32  PC of instruction in D
- imm16  in  16  branch offset
- imm26  in  26  jump index
- rs_val  in  32  forwarded rs value
- exc_req  in  1  exception taken in M
- eret_req  in  1  eret in M
- epc  in  32  return address for eret
- F_PC  out  32  registered fetch PC
- NPC  out  32  combinational next F_PC
- ras_miss  out  1  registered one-cycle misprediction pulse
- ras_count  out  $clog2(RAS_DEPTH)+1  valid RAS entries
- redirect_cnt  out  CNT_W  saturating count of taken control transfers

## Operation
- Target selection (D op, no stall, no exc/eret):
  - SEQ, BR not taken: F_PC+4
  - BR taken: D_PC+4+sign_ext(imm16)<<2
  - J/JAL: {F_PC[31:28], imm26, 2'b00}
  - JR/JALR: rs_val; the RAS never supplies the target
- NPC priority: exc_req → EXC_VEC; else eret_req → epc; else stall → F_PC; else target above.
- All additions are modulo 2^32; carries are discarded.
- RAS actions occur only on cycles where op is applied (stall=0, exc_req=0, eret_req=0):
  - JAL, JALR: push D_PC+8.
  - JR with is_ra=1: pop.
  - Push when full: overwrite the oldest entry; the pointer wraps and ras_count stays at RAS_DEPTH.
  - Pop: compare the popped value with rs_val. A mismatch sets ras_miss next cycle.
  - Pop when empty: ras_miss=1 and ras_count stays 0.
  - JR with is_ra=0: no RAS action.
- redirect_cnt increments by 1 on each applied cycle with:
  - BR taken, J, JAL, JR or JALR.
  - Excluded: exc/eret redirects and stalled cycles.
  - Saturates at 2^CNT_W−1.
- exc_req or eret_req in the same cycle as a D op: the D op is flushed. There is no RAS change, no count, and ras_miss=0.

## Timing
- Reset values: F_PC=RESET_PC, all RAS entries 0, pointer 0, ras_count=0, ras_miss=0, redirect_cnt=0. NPC follows combinationally from these.
- Reset asserted mid-operation: reset values appear immediately, without waiting for a clock edge. Any RAS push/pop in flight is lost.
- F_PC<=NPC on every edge; latency is one cycle from D decision to new F_PC.
- A stall holds F_PC, the RAS and the counter. The held D op is applied on the first cycle with stall=0, exactly once.
- exc_req/eret_req override stall in the same cycle.
- ras_miss is high for exactly one cycle after the offending pop edge.

## Test plan
- Reset release, 3 SEQ cycles → F_PC 0x3000, 0x3004, 0x3008, 0x300C; redirect_cnt=0.
- BR at D_PC=0x3010, imm16=0xFFFC, cmp_suc=1 → F_PC=0x3004, redirect_cnt=1. Repeat with cmp_suc=0 → F_PC_prev+4, count unchanged.
- JAL at D_PC=0x3000, then JR is_ra=1 with rs_val=0x3008 → ras_count 1→0, ras_miss=0. Same with rs_val=0x3100 → ras_miss pulses for one cycle.
- RAS_DEPTH=4:
  - Five JALs at D_PC 0x3000..0x3040 step 0x10 → ras_count=4.
  - Then four JR is_ra=1 pops → popped values 0x3048, 0x3038, 0x3028, 0x3018.
  - A fifth pop → ras_miss=1, ras_count=0.
- JAL held with stall=1 for 3 cycles, then released → F_PC frozen during the stall; exactly one push and one count.
- exc_req with stall=1 and npc_op=JAL → F_PC=0x4180, no push. Next eret_req with epc=0x3020 → F_PC=0x3020.
